// File: rtl/systolic_tile_feeder_pkg.sv
// systolic_tile_feeder_pkg: shared FSM encoding, width defaults and load lane macros
`ifndef SYSTOLIC_INPUT_WIDTH
`define SYSTOLIC_INPUT_WIDTH 8
`endif
`ifndef SYSTOLIC_RESULT_WIDTH
`define SYSTOLIC_RESULT_WIDTH 32
`endif
`define STF_A_LANE(w) 4*(w)-1:0
`define STF_B_LANE(w) 8*(w)-1:4*(w)
package systolic_tile_feeder_pkg;
  localparam int DEF_INPUT_WIDTH = `SYSTOLIC_INPUT_WIDTH;
  localparam int DEF_RESULT_WIDTH = `SYSTOLIC_RESULT_WIDTH;
  localparam int DEF_TIMEOUT = 64;
  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_ARM = 3'd1,
    S_CLEAR = 3'd2,
    S_FEED = 3'd3,
    S_WAIT = 3'd4,
    S_DRAIN = 3'd5
  } state_t;
endpackage

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures the 16 accumulators and serializes them as 4 row beats
module systolic_result_drain #(
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_cap,
  input  logic [16*AW-1:0] i_res,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [4*AW-1:0] o_data,
  output logic            o_last,
  output logic            o_done
);
  logic [16*AW-1:0] r_res;
  logic [1:0] r_row;
  logic r_valid;
  logic w_hs;
  assign w_hs = r_valid && i_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_row <= '0;
    end else if (i_cap) begin
      r_valid <= 1'b1;
      r_row <= '0;
    end else if (w_hs) begin
      r_row <= r_row + 1'b1;
      r_valid <= r_row != 2'd3;
    end
  end
  always_ff @(posedge clk) if (i_cap) r_res <= i_res;
  assign o_valid = r_valid;
  assign o_data = r_valid ? r_res[32'(r_row)*4*AW +: 4*AW] : '0;
  assign o_last = r_valid && r_row == 2'd3;
  assign o_done = w_hs && r_row == 2'd3;
endmodule

// File: rtl/systolic_tile_feeder.sv
// systolic_tile_feeder: buffers one operand tile, runs the array handshake and drains results
module systolic_tile_feeder
  import systolic_tile_feeder_pkg::*;
#(
  parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int ACC_WIDTH = DEF_RESULT_WIDTH,
  parameter int VECTOR_LENGTH = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [8*INPUT_WIDTH-1:0] load_data,
  input  logic                     arr_ready_for_feed,
  output logic                     arr_tile_clear,
  output logic                     arr_feed_valid,
  output logic [4*INPUT_WIDTH-1:0] arr_row_data_bus,
  output logic [4*INPUT_WIDTH-1:0] arr_col_data_bus,
  input  logic                     arr_tile_done,
  input  logic [16*ACC_WIDTH-1:0]  arr_tile_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*ACC_WIDTH-1:0]   out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [15:0]              tile_count
);
  localparam int KW = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(VECTOR_LENGTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_state_n;
  logic [KW-1:0] r_k, w_k_sel;
  logic [TW-1:0] r_t;
  logic [8*INPUT_WIDTH-1:0] r_buf [VECTOR_LENGTH];
  logic [8*INPUT_WIDTH-1:0] w_beat;
  logic [4*INPUT_WIDTH-1:0] r_row_bus, r_col_bus;
  logic r_fv, r_terr;
  logic [15:0] r_cnt;
  logic w_ld, w_last_k, w_t_last, w_cap, w_fv_n, w_drained;
  assign load_ready = r_state == S_LOAD;
  assign w_ld = load_valid && load_ready;
  assign w_last_k = r_k == K_LAST;
  assign w_t_last = r_t == T_LAST;
  assign w_cap = r_state == S_WAIT && arr_tile_done;
  assign w_fv_n = r_state == S_CLEAR || (r_state == S_FEED && !w_last_k);
  // The bus registers are loaded one beat ahead of the beat being displayed
  assign w_k_sel = (r_state == S_FEED) ? r_k + 1'b1 : '0;
  assign w_beat = r_buf[w_k_sel];
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_LOAD:  w_state_n = (w_ld && w_last_k) ? S_ARM : S_LOAD;
      S_ARM:   w_state_n = arr_ready_for_feed ? S_CLEAR : S_ARM;
      S_CLEAR: w_state_n = S_FEED;
      S_FEED:  w_state_n = w_last_k ? S_WAIT : S_FEED;
      S_WAIT:  w_state_n = arr_tile_done ? S_DRAIN : (w_t_last ? S_LOAD : S_WAIT);
      S_DRAIN: w_state_n = w_drained ? S_LOAD : S_DRAIN;
      default: w_state_n = S_LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_k <= '0;
      r_t <= '0;
      r_fv <= 1'b0;
      r_row_bus <= '0;
      r_col_bus <= '0;
      r_terr <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_ld || r_state == S_FEED) r_k <= w_last_k ? '0 : r_k + 1'b1;
      r_t <= (r_state == S_WAIT) ? r_t + 1'b1 : '0;
      r_fv <= w_fv_n;
      r_row_bus <= w_fv_n ? w_beat[`STF_A_LANE(INPUT_WIDTH)] : '0;
      r_col_bus <= w_fv_n ? w_beat[`STF_B_LANE(INPUT_WIDTH)] : '0;
      if (w_ld && w_last_k) r_terr <= 1'b0;
      else if (r_state == S_WAIT && !arr_tile_done && w_t_last) r_terr <= 1'b1;
      if (w_cap) r_cnt <= r_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) if (w_ld) r_buf[r_k] <= load_data;
  systolic_result_drain #(.AW(ACC_WIDTH)) u_drain (
    .clk(clk),
    .rst(rst),
    .i_cap(w_cap),
    .i_res(arr_tile_result),
    .i_ready(out_ready),
    .o_valid(out_valid),
    .o_data(out_data),
    .o_last(out_last),
    .o_done(w_drained)
  );
  assign arr_tile_clear = r_state == S_CLEAR;
  assign arr_feed_valid = r_fv;
  assign arr_row_data_bus = r_row_bus;
  assign arr_col_data_bus = r_col_bus;
  assign busy = r_state != S_LOAD;
  assign timeout_err = r_terr;
  assign tile_count = r_cnt;
endmodule

// File: tb/tb_systolic_tile_feeder.sv
// tb_systolic_tile_feeder: directed scenarios against a behavioural array stub
module tb_systolic_tile_feeder;
  localparam int IW = 16;
  localparam int AW = 32;
  localparam int K = 4;
  logic clk = 0, rst = 1, load_valid = 0, out_ready = 0;
  logic [8*IW-1:0] load_data = '0;
  logic arr_ready_for_feed, arr_tile_done;
  logic [16*AW-1:0] arr_tile_result;
  logic load_ready, arr_tile_clear, arr_feed_valid, out_valid, out_last, busy, timeout_err;
  logic [4*IW-1:0] arr_row_data_bus, arr_col_data_bus;
  logic [4*AW-1:0] out_data;
  logic [15:0] tile_count;
  int checks = 0, errors = 0;
  logic s_busy = 0, s_done = 0, tb_done = 0, stub_hold = 0, stub_never = 0;
  int s_cd = 0;
  int stub_n = 5;
  systolic_tile_feeder #(.INPUT_WIDTH(IW), .ACC_WIDTH(AW), .VECTOR_LENGTH(K), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .arr_ready_for_feed(arr_ready_for_feed), .arr_tile_clear(arr_tile_clear), .arr_feed_valid(arr_feed_valid),
    .arr_row_data_bus(arr_row_data_bus), .arr_col_data_bus(arr_col_data_bus), .arr_tile_done(arr_tile_done),
    .arr_tile_result(arr_tile_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .timeout_err(timeout_err), .tile_count(tile_count)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 16; i++) arr_tile_result[i*AW +: AW] = AW'(i + 100);
  assign arr_ready_for_feed = !s_busy && !stub_hold;
  assign arr_tile_done = s_done | tb_done;
  // Array stub: busy from clear until done; done fires stub_n cycles after the last feed beat
  always @(posedge clk) begin
    s_done <= 0;
    if (rst) begin
      s_busy <= 0;
      s_cd <= 0;
    end else begin
      if (arr_tile_clear) s_busy <= 1;
      if (arr_feed_valid) s_cd <= stub_n;
      else if (s_cd != 0) begin
        s_cd <= s_cd - 1;
        if (s_cd == 1) begin
          s_busy <= 0;
          if (!stub_never) s_done <= 1;
        end
      end
    end
  end
  function automatic logic [4*IW-1:0] a_bus(input int k, input int off);
    logic [4*IW-1:0] v;
    for (int r = 0; r < 4; r++) v[r*IW +: IW] = IW'(16*r + k + off);
    return v;
  endfunction
  function automatic logic [4*IW-1:0] b_bus(input int k);
    logic [4*IW-1:0] v;
    for (int c = 0; c < 4; c++) v[c*IW +: IW] = IW'(256 + 4*k + c);
    return v;
  endfunction
  function automatic logic [4*AW-1:0] exp_row(input int r);
    logic [4*AW-1:0] v;
    for (int c = 0; c < 4; c++) v[c*AW +: AW] = AW'(100 + 4*r + c);
    return v;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_tile(input int off);
    for (int k = 0; k < K; k++) begin
      load_data = {b_bus(k), a_bus(k, off)};
      load_valid = 1;
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready beat %0d got %b exp 1", k, load_ready); end
      tick;
    end
    load_valid = 0;
  endtask
  task automatic wait_clear;
    int n = 0;
    while (arr_tile_clear !== 1'b1 && n < 50) begin tick; n++; end
    checks++; if (arr_tile_clear !== 1'b1) begin errors++; $display("FAIL wait_clear got %b exp 1", arr_tile_clear); end
  endtask
  task automatic feed_beats(input int off);
    checks++; if (arr_feed_valid !== 1'b0) begin errors++; $display("FAIL clear_fv got %b exp 0", arr_feed_valid); end
    for (int k = 0; k < K; k++) begin
      tick;
      checks++; if (arr_feed_valid !== 1'b1 || arr_tile_clear !== 1'b0) begin errors++; $display("FAIL feed_valid beat %0d got %b/%b exp 1/0", k, arr_feed_valid, arr_tile_clear); end
      checks++; if (arr_row_data_bus !== a_bus(k, off)) begin errors++; $display("FAIL row_bus beat %0d got %h exp %h", k, arr_row_data_bus, a_bus(k, off)); end
      checks++; if (arr_col_data_bus !== b_bus(k)) begin errors++; $display("FAIL col_bus beat %0d got %h exp %h", k, arr_col_data_bus, b_bus(k)); end
    end
    tick;
    checks++; if (arr_feed_valid !== 1'b0 || arr_row_data_bus !== '0 || arr_col_data_bus !== '0) begin errors++; $display("FAIL feed_end got %b %h %h exp 0 0 0", arr_feed_valid, arr_row_data_bus, arr_col_data_bus); end
  endtask
  task automatic drain(input bit toggle, input bit hold);
    int n = 0, row = 0, i = 0;
    while (arr_tile_done !== 1'b1 && n < 200) begin tick; n++; end
    checks++; if (arr_tile_done !== 1'b1) begin errors++; $display("FAIL wait_done got %b exp 1", arr_tile_done); end
    tick;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL done_to_valid got %b exp 1", out_valid); end
    while (row < 4 && i < 40) begin
      out_ready = toggle ? (i % 3 == 0) : 1'b1;
      checks++; if (out_valid !== 1'b1 || out_data !== exp_row(row)) begin errors++; $display("FAIL out_row %0d got %b %h exp 1 %h", row, out_valid, out_data, exp_row(row)); end
      checks++; if (out_last !== (row == 3)) begin errors++; $display("FAIL out_last row %0d got %b exp %b", row, out_last, row == 3); end
      if (hold) begin
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL drain_load_ready got %b exp 0", load_ready); end
      end
      tick;
      if (out_ready) row++;
      i++;
    end
    out_ready = 0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL drain_end got %b %b %b exp 0 0 1", out_valid, busy, load_ready); end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) tick;
    checks++; if (load_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b %b exp 1 0", load_ready, busy); end
    checks++; if (arr_tile_clear !== 1'b0 || arr_feed_valid !== 1'b0 || arr_row_data_bus !== '0 || arr_col_data_bus !== '0) begin errors++; $display("FAIL reset_arr got %b %b %h %h exp 0", arr_tile_clear, arr_feed_valid, arr_row_data_bus, arr_col_data_bus); end
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL reset_out got %b %b %h exp 0", out_valid, out_last, out_data); end
    checks++; if (tile_count !== 16'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d %b exp 0 0", tile_count, timeout_err); end
    rst = 0;
    tick;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", load_ready); end
  endtask
  task automatic test_basic;
    load_tile(0);
    checks++; if (arr_tile_clear !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL arm_state got %b %b %b exp 0 1 0", arr_tile_clear, busy, load_ready); end
    tick;
    checks++; if (arr_tile_clear !== 1'b1) begin errors++; $display("FAIL clear_latency got %b exp 1", arr_tile_clear); end
    feed_beats(0);
    drain(0, 0);
    checks++; if (tile_count !== 16'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", tile_count); end
  endtask
  task automatic test_arm_hold;
    stub_hold = 1;
    load_tile(32);
    for (int i = 0; i < 10; i++) begin
      checks++; if (arr_tile_clear !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL arm_hold cyc %0d got %b %b exp 0 1", i, arr_tile_clear, busy); end
      tick;
    end
    stub_hold = 0;
    tick;
    checks++; if (arr_tile_clear !== 1'b1) begin errors++; $display("FAIL arm_release got %b exp 1", arr_tile_clear); end
    feed_beats(32);
    drain(1, 0);
    checks++; if (tile_count !== 16'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", tile_count); end
  endtask
  task automatic test_timeout;
    stub_never = 1;
    load_tile(64);
    wait_clear;
    feed_beats(64);
    for (int i = 0; i < 63; i++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wait_cyc %0d got %b %b exp 0 1", i, out_valid, busy); end
      tick;
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL early_timeout got %b exp 0", timeout_err); end
    tick;
    checks++; if (timeout_err !== 1'b1 || load_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout got %b %b %b exp 1 1 0", timeout_err, load_ready, busy); end
    checks++; if (out_valid !== 1'b0 || tile_count !== 16'd2) begin errors++; $display("FAIL timeout_out got %b %0d exp 0 2", out_valid, tile_count); end
    stub_never = 0;
    repeat (5) tick;
    load_tile(0);
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b exp 0", timeout_err); end
    wait_clear;
    feed_beats(0);
    drain(0, 0);
    checks++; if (tile_count !== 16'd3) begin errors++; $display("FAIL after_timeout_count got %0d exp 3", tile_count); end
  endtask
  task automatic test_reset_mid_feed;
    load_tile(0);
    wait_clear;
    repeat (3) tick;
    checks++; if (arr_feed_valid !== 1'b1 || arr_row_data_bus !== a_bus(2, 0)) begin errors++; $display("FAIL pre_reset_beat got %b %h exp 1 %h", arr_feed_valid, arr_row_data_bus, a_bus(2, 0)); end
    rst = 1;
    tick;
    checks++; if (arr_feed_valid !== 1'b0 || arr_tile_clear !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got %b %b %b %b exp 0 0 0 1", arr_feed_valid, arr_tile_clear, busy, load_ready); end
    checks++; if (tile_count !== 16'd0 || arr_row_data_bus !== '0) begin errors++; $display("FAIL mid_reset_state got %0d %h exp 0 0", tile_count, arr_row_data_bus); end
    rst = 0;
    tick;
    tb_done = 1;
    tick;
    tb_done = 0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL spurious_done cyc %0d got %b %b exp 0 0", i, out_valid, busy); end
      tick;
    end
  endtask
  task automatic test_back_to_back;
    load_tile(0);
    wait_clear;
    feed_beats(0);
    load_data = {b_bus(0), a_bus(0, 16)};
    load_valid = 1;
    drain(0, 1);
    load_tile(16);
    wait_clear;
    feed_beats(16);
    drain(0, 0);
    checks++; if (tile_count !== 16'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", tile_count); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_arm_hold;
    test_timeout;
    test_reset_mid_feed;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
